// File: rtl/noc_output_arbiter_if.sv
// Handshake bundle between the input ports and one output-link arbiter.
// The arbiter connects to the slave modport; the requesting side uses master.
interface noc_output_arbiter_if #(
    parameter int NPORT = 5,
    parameter int CW    = 4
);
    logic [NPORT-1:0] req;
    logic [NPORT-1:0] tail;
    logic             credit_return;
    logic [NPORT-1:0] grant;
    logic             fire;
    logic [CW-1:0]    credits;
    logic             busy;
    logic             credit_err;

    modport slave (
        input  req,
        input  tail,
        input  credit_return,
        output grant,
        output fire,
        output credits,
        output busy,
        output credit_err
    );

    modport master (
        output req,
        output tail,
        output credit_return,
        input  grant,
        input  fire,
        input  credits,
        input  busy,
        input  credit_err
    );
endinterface

// File: rtl/noc_output_arbiter.sv
// Round-robin, packet-locking arbiter for one router output link, with
// credit-based flow control toward the downstream input FIFO.
module noc_output_arbiter #(
    parameter int NPORT   = 5,
    parameter int CREDITS = 8,
    parameter int CW      = 4
) (
    input  logic                clk,
    input  logic                rst,
    noc_output_arbiter_if.slave arb
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    logic [0:0]       state_q,  state_d;
    logic [NPORT-1:0] grant_q,  grant_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic             credit_err_q, credit_err_d;

    logic             owner_req;
    logic             owner_tail;
    logic             fire;
    logic [PW-1:0]    winner;

    // First requester at or above ptr, wrapping past NPORT-1 back to 0.
    function automatic logic [NPORT-1:0] rr_pick(input logic [NPORT-1:0] r,
                                                 input logic [PW-1:0]    ptr);
        logic [NPORT-1:0] w;
        logic             found;
        int               idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            idx = (int'(ptr) + i) % NPORT;
            if (!found && r[idx[PW-1:0]]) begin
                w[idx[PW-1:0]] = 1'b1;
                found          = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [PW-1:0] onehot_to_idx(input logic [NPORT-1:0] oh);
        logic [PW-1:0] k;
        k = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (oh[i]) k = PW'(i);
        end
        return k;
    endfunction

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
        if (idx == PW'(NPORT - 1)) return '0;
        return idx + 1'b1;
    endfunction

    assign owner_req  = |(grant_q & arb.req);
    assign owner_tail = |(grant_q & arb.tail);
    assign winner     = onehot_to_idx(grant_q);

    // A flit moves only from the locked owner, and only into a free slot.
    assign fire = rst && (state_q == ST_LOCKED) && owner_req && (credits_q != '0);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (arb.req != '0) begin
                    grant_d = rr_pick(arb.req, rr_ptr_q);
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (fire && owner_tail) begin
                    grant_d  = '0;
                    state_d  = ST_IDLE;
                    rr_ptr_d = ptr_after(winner);
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Returned credit with the buffer already fully free is a protocol error.
    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        case ({fire, arb.credit_return})
            2'b10: credits_d = credits_q - 1'b1;
            2'b01: begin
                if (credits_q == CRED_MAX) credit_err_d = 1'b1;
                else                       credits_d    = credits_q + 1'b1;
            end
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            credits_q    <= CRED_MAX;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign arb.grant      = grant_q;
    assign arb.fire       = fire;
    assign arb.credits    = credits_q;
    assign arb.busy       = (state_q == ST_LOCKED);
    assign arb.credit_err = credit_err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter: reset, single flit, round-robin,
// wormhole lock, credit exhaustion, credit arithmetic and mid-packet reset.
module tb_noc_output_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    noc_output_arbiter_if #(.NPORT(5), .CW(4)) bus ();

    noc_output_arbiter #(.NPORT(5), .CREDITS(8), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus.slave)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        bus.req           = '0;
        bus.tail          = '0;
        bus.credit_return = 1'b0;
        rst               = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        bus.req = 5'b00001; bus.tail = '0; bus.credit_return = 1'b0;
        rst = 1'b0;
        step();
        n_checks++; if (bus.grant !== 5'b00000) begin n_fail++; $display("FAIL reset_grant: got %b exp 00000", bus.grant); end
        n_checks++; if (bus.credits !== 4'd8) begin n_fail++; $display("FAIL reset_credits: got %0d exp 8", bus.credits); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
        n_checks++; if (bus.credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_credit_err: got %b exp 0", bus.credit_err); end
        n_checks++; if (bus.fire !== 1'b0) begin n_fail++; $display("FAIL reset_fire: got %b exp 0", bus.fire); end
        bus.req = '0;
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_flit;
        do_reset();
        bus.req = 5'b00001; bus.tail = 5'b00001;
        n_checks++; if (bus.fire !== 1'b0) begin n_fail++; $display("FAIL single_idle_fire: got %b exp 0", bus.fire); end
        step();
        n_checks++; if (bus.grant !== 5'b00001) begin n_fail++; $display("FAIL single_grant: got %b exp 00001", bus.grant); end
        n_checks++; if (bus.fire !== 1'b1) begin n_fail++; $display("FAIL single_fire: got %b exp 1", bus.fire); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", bus.busy); end
        step();
        bus.req = '0; bus.tail = '0;
        n_checks++; if (bus.grant !== 5'b00000) begin n_fail++; $display("FAIL single_release: got %b exp 00000", bus.grant); end
        n_checks++; if (bus.credits !== 4'd7) begin n_fail++; $display("FAIL single_credits: got %0d exp 7", bus.credits); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_off: got %b exp 0", bus.busy); end
    endtask

    task automatic test_round_robin;
        logic [4:0] exp_g [0:5];
        logic       exp_f [0:5];
        exp_g = '{5'b00001, 5'b00000, 5'b10000, 5'b00000, 5'b00001, 5'b00000};
        exp_f = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        bus.req = 5'b10001; bus.tail = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 5) begin bus.req = '0; bus.tail = '0; end
            n_checks++; if (bus.grant !== exp_g[k]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, bus.grant, exp_g[k]); end
            n_checks++; if (bus.fire !== exp_f[k]) begin n_fail++; $display("FAIL rr_fire[%0d]: got %b exp %b", k, bus.fire, exp_f[k]); end
        end
        n_checks++; if (bus.credits !== 4'd5) begin n_fail++; $display("FAIL rr_credits: got %0d exp 5", bus.credits); end
    endtask

    task automatic test_wormhole;
        do_reset();
        bus.req = 5'b00100; bus.tail = '0;
        step();
        bus.req = 5'b00101;
        for (int k = 0; k < 4; k++) begin
            bus.tail = (k == 3) ? 5'b00100 : 5'b00000;
            n_checks++; if (bus.grant !== 5'b00100) begin n_fail++; $display("FAIL worm_grant[%0d]: got %b exp 00100", k, bus.grant); end
            n_checks++; if (bus.fire !== 1'b1) begin n_fail++; $display("FAIL worm_fire[%0d]: got %b exp 1", k, bus.fire); end
            step();
        end
        bus.req = 5'b00001; bus.tail = '0;
        n_checks++; if (bus.grant !== 5'b00000) begin n_fail++; $display("FAIL worm_bubble: got %b exp 00000", bus.grant); end
        n_checks++; if (bus.fire !== 1'b0) begin n_fail++; $display("FAIL worm_bubble_fire: got %b exp 0", bus.fire); end
        step();
        bus.tail = 5'b00001;
        n_checks++; if (bus.grant !== 5'b00001) begin n_fail++; $display("FAIL worm_next_owner: got %b exp 00001", bus.grant); end
        n_checks++; if (bus.fire !== 1'b1) begin n_fail++; $display("FAIL worm_next_fire: got %b exp 1", bus.fire); end
        step();
        bus.req = '0; bus.tail = '0;
        n_checks++; if (bus.credits !== 4'd3) begin n_fail++; $display("FAIL worm_credits: got %0d exp 3", bus.credits); end
    endtask

    task automatic test_credit_exhaustion;
        do_reset();
        bus.req = 5'b00001; bus.tail = '0;
        step();
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (bus.fire !== 1'b1) begin n_fail++; $display("FAIL exh_fire[%0d]: got %b exp 1", k, bus.fire); end
            step();
        end
        n_checks++; if (bus.credits !== 4'd0) begin n_fail++; $display("FAIL exh_credits0: got %0d exp 0", bus.credits); end
        n_checks++; if (bus.fire !== 1'b0) begin n_fail++; $display("FAIL exh_stall: got %b exp 0", bus.fire); end
        step();
        n_checks++; if (bus.grant !== 5'b00001) begin n_fail++; $display("FAIL exh_hold: got %b exp 00001", bus.grant); end
        n_checks++; if (bus.fire !== 1'b0) begin n_fail++; $display("FAIL exh_stall2: got %b exp 0", bus.fire); end
        bus.credit_return = 1'b1; bus.tail = 5'b00001;
        step();
        bus.credit_return = 1'b0;
        n_checks++; if (bus.credits !== 4'd1) begin n_fail++; $display("FAIL exh_credits1: got %0d exp 1", bus.credits); end
        n_checks++; if (bus.fire !== 1'b1) begin n_fail++; $display("FAIL exh_resume: got %b exp 1", bus.fire); end
        step();
        bus.req = '0; bus.tail = '0;
        n_checks++; if (bus.credits !== 4'd0) begin n_fail++; $display("FAIL exh_credits_end: got %0d exp 0", bus.credits); end
        n_checks++; if (bus.grant !== 5'b00000) begin n_fail++; $display("FAIL exh_release: got %b exp 00000", bus.grant); end
        n_checks++; if (bus.credit_err !== 1'b0) begin n_fail++; $display("FAIL exh_err: got %b exp 0", bus.credit_err); end
    endtask

    task automatic test_credit_math;
        do_reset();
        bus.req = 5'b00001; bus.tail = '0;
        step();
        for (int k = 0; k < 5; k++) step();
        n_checks++; if (bus.credits !== 4'd3) begin n_fail++; $display("FAIL math_credits3: got %0d exp 3", bus.credits); end
        n_checks++; if (bus.fire !== 1'b1) begin n_fail++; $display("FAIL math_fire: got %b exp 1", bus.fire); end
        bus.credit_return = 1'b1;
        step();
        n_checks++; if (bus.credits !== 4'd3) begin n_fail++; $display("FAIL math_fire_and_return: got %0d exp 3", bus.credits); end
        bus.credit_return = 1'b0; bus.tail = 5'b00001;
        step();
        bus.req = '0; bus.tail = '0;
        n_checks++; if (bus.credits !== 4'd2) begin n_fail++; $display("FAIL math_credits2: got %0d exp 2", bus.credits); end
        bus.credit_return = 1'b1;
        for (int k = 0; k < 6; k++) step();
        n_checks++; if (bus.credits !== 4'd8) begin n_fail++; $display("FAIL math_refill: got %0d exp 8", bus.credits); end
        n_checks++; if (bus.credit_err !== 1'b0) begin n_fail++; $display("FAIL math_err_early: got %b exp 0", bus.credit_err); end
        step();
        bus.credit_return = 1'b0;
        n_checks++; if (bus.credits !== 4'd8) begin n_fail++; $display("FAIL math_saturate: got %0d exp 8", bus.credits); end
        n_checks++; if (bus.credit_err !== 1'b1) begin n_fail++; $display("FAIL math_err_set: got %b exp 1", bus.credit_err); end
        step();
        n_checks++; if (bus.credit_err !== 1'b1) begin n_fail++; $display("FAIL math_err_sticky: got %b exp 1", bus.credit_err); end
    endtask

    task automatic test_reset_mid_packet;
        do_reset();
        bus.req = 5'b10000; bus.tail = '0;
        step();
        for (int k = 0; k < 6; k++) step();
        n_checks++; if (bus.credits !== 4'd2) begin n_fail++; $display("FAIL mid_credits2: got %0d exp 2", bus.credits); end
        n_checks++; if (bus.grant !== 5'b10000) begin n_fail++; $display("FAIL mid_grant: got %b exp 10000", bus.grant); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.grant !== 5'b00000) begin n_fail++; $display("FAIL mid_rst_grant: got %b exp 00000", bus.grant); end
        n_checks++; if (bus.credits !== 4'd8) begin n_fail++; $display("FAIL mid_rst_credits: got %0d exp 8", bus.credits); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b exp 0", bus.busy); end
        n_checks++; if (bus.fire !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fire: got %b exp 0", bus.fire); end
        step();
        rst = 1'b1;
        bus.req = 5'b10001;
        step();
        bus.req = '0;
        n_checks++; if (bus.grant !== 5'b00001) begin n_fail++; $display("FAIL mid_after_rr: got %b exp 00001", bus.grant); end
    endtask

    initial begin
        bus.req           = '0;
        bus.tail          = '0;
        bus.credit_return = 1'b0;
        step();
        test_reset();
        test_single_flit();
        test_round_robin();
        test_wormhole();
        test_credit_exhaustion();
        test_credit_math();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
